// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_pkg
//  Brief    : Shared RV32IM decode constants, ALU codes and control bundle.
//  Revision : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct7 groups for OP / shift-immediate
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // ALU operation codes
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    // Branch funct3 codes
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Fully-specified SYSTEM encodings with funct3 = 000
    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

    // Decoded control bundle (everything except ALU result / branch outcome)
    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [4:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        is_branch;
        logic        jal_jump;
        logic        jalr_jump;
        logic [2:0]  b_type;
        logic        is_load;
        logic        is_store;
        logic [2:0]  mem_type;
        logic        is_div;
        logic [2:0]  div_op;
        logic        is_lui;
        logic        is_auipc;
        logic        csr_we;
        logic [2:0]  csr_func;
        logic [11:0] csr_addr;
        logic        is_mret;
        logic        cpu_halt;
        logic        illegal;
    } ctrl_t;

    // Base-integer funct3 to ALU code (SUB/SRA selected separately by funct7)
    function automatic logic [4:0] alu_op_for_f3(input logic [2:0] f3);
        logic [4:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_alu.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_alu
//  Brief    : Combinational RV32 integer ALU.
//  Revision : 1.0 - initial release
// ============================================================================
module rv32_alu
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [4:0] w_shamt;
    assign w_shamt = b[4:0];

    // Select the operation result; unknown codes yield zero
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << w_shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> w_shamt;
            ALU_SRA:  result = $signed(a) >>> w_shamt;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32_branch_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_branch_cmp
//  Brief    : Combinational branch condition evaluator.
//  Revision : 1.0 - initial release
// ============================================================================
module rv32_branch_cmp
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_branch,
    input  logic [2:0]      b_type,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            take_branch
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (a == b);
    assign w_lt  = ($signed(a) < $signed(b));
    assign w_ltu = (a < b);

    // Evaluate the condition only for decoded branches
    always_comb begin
        take_branch = 1'b0;
        if (is_branch) begin
            case (b_type)
                BR_BEQ:  take_branch = w_eq;
                BR_BNE:  take_branch = !w_eq;
                BR_BLT:  take_branch = w_lt;
                BR_BGE:  take_branch = !w_lt;
                BR_BLTU: take_branch = w_ltu;
                BR_BGEU: take_branch = !w_ltu;
                default: take_branch = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv32_decode_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_decode_exec_unit
//  Brief    : RV32IM decoder + ALU + branch compare with one output register.
//  Revision : 1.0 - initial release
// ============================================================================
module rv32_decode_exec_unit
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [31:0]     instr,
    input  logic [31:0]     pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            out_valid,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [31:0]     imm,
    output logic [4:0]      alu_op,
    output logic            alu_src,
    output logic            reg_write,
    output logic            is_branch,
    output logic            jal_jump,
    output logic            jalr_jump,
    output logic [2:0]      b_type,
    output logic            is_load,
    output logic            is_store,
    output logic [2:0]      mem_type,
    output logic            is_div,
    output logic [2:0]      div_op,
    output logic            is_lui,
    output logic            is_auipc,
    output logic            csr_we,
    output logic [2:0]      csr_func,
    output logic [11:0]     csr_addr,
    output logic            is_mret,
    output logic            cpu_halt,
    output logic            illegal,
    output logic [XLEN-1:0] alu_result,
    output logic            take_branch
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_u  = {instr[31:12], 12'b0};
    assign w_imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    ctrl_t           w_dec;
    logic [XLEN-1:0] w_alu_b;
    logic [XLEN-1:0] w_alu_result;
    logic            w_take_branch;

    // Decode instruction; an illegal encoding keeps only the register fields and immediate
    always_comb begin
        ctrl_t      d;
        logic       bad;
        logic [31:0] imm_sel;
        d       = '0;
        bad     = 1'b0;
        imm_sel = '0;
        d.alu_op = ALU_ADD;
        case (w_opcode)
            OPC_OP: begin
                d.reg_write = 1'b1;
                case (w_funct7)
                    F7_BASE: d.alu_op = alu_op_for_f3(w_funct3);
                    F7_ALT: begin
                        if (w_funct3 == 3'b000)      d.alu_op = ALU_SUB;
                        else if (w_funct3 == 3'b101) d.alu_op = ALU_SRA;
                        else                         bad = 1'b1;
                    end
                    F7_MULDIV: begin
                        d.is_div = 1'b1;
                        d.div_op = w_funct3;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                imm_sel     = w_imm_i;
                d.alu_src   = 1'b1;
                d.reg_write = 1'b1;
                d.alu_op    = alu_op_for_f3(w_funct3);
                if (w_funct3 == 3'b001 && w_funct7 != F7_BASE) bad = 1'b1;
                if (w_funct3 == 3'b101) begin
                    if (w_funct7 == F7_ALT)       d.alu_op = ALU_SRA;
                    else if (w_funct7 != F7_BASE) bad = 1'b1;
                end
            end
            OPC_LOAD: begin
                imm_sel     = w_imm_i;
                d.alu_src   = 1'b1;
                d.reg_write = 1'b1;
                d.is_load   = 1'b1;
                d.mem_type  = w_funct3;
                if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111) bad = 1'b1;
            end
            OPC_STORE: begin
                imm_sel    = w_imm_s;
                d.alu_src  = 1'b1;
                d.is_store = 1'b1;
                d.mem_type = w_funct3;
                if (w_funct3 > 3'b010) bad = 1'b1;
            end
            OPC_BRANCH: begin
                imm_sel     = w_imm_b;
                d.is_branch = 1'b1;
                d.b_type    = w_funct3;
                if (w_funct3 == 3'b010 || w_funct3 == 3'b011) bad = 1'b1;
            end
            OPC_JAL: begin
                imm_sel     = w_imm_j;
                d.jal_jump  = 1'b1;
                d.reg_write = 1'b1;
            end
            OPC_JALR: begin
                imm_sel     = w_imm_i;
                d.jalr_jump = 1'b1;
                d.alu_src   = 1'b1;
                d.reg_write = 1'b1;
            end
            OPC_LUI: begin
                imm_sel     = w_imm_u;
                d.is_lui    = 1'b1;
                d.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                imm_sel     = w_imm_u;
                d.is_auipc  = 1'b1;
                d.reg_write = 1'b1;
            end
            OPC_SYSTEM: begin
                imm_sel = w_imm_i;
                if (w_funct3 == 3'b000) begin
                    if (instr == INSTR_ECALL || instr == INSTR_EBREAK) d.cpu_halt = 1'b1;
                    else if (instr == INSTR_MRET)                      d.is_mret  = 1'b1;
                    else                                               bad = 1'b1;
                end else if (w_funct3 == 3'b100) begin
                    bad = 1'b1;
                end else begin
                    d.csr_we    = 1'b1;
                    d.csr_func  = w_funct3;
                    d.csr_addr  = instr[31:20];
                    d.reg_write = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            d         = '0;
            d.alu_op  = ALU_ADD;
            d.illegal = 1'b1;
        end
        d.rd  = instr[11:7];
        d.rs1 = instr[19:15];
        d.rs2 = instr[24:20];
        d.imm = imm_sel;
        w_dec = d;
    end

    assign w_alu_b = w_dec.alu_src ? w_dec.imm : rs2_val;

    rv32_alu #(.XLEN(XLEN)) u_alu (
        .op     (w_dec.alu_op),
        .a      (rs1_val),
        .b      (w_alu_b),
        .result (w_alu_result)
    );

    rv32_branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
        .is_branch   (w_dec.is_branch),
        .b_type      (w_dec.b_type),
        .a           (rs1_val),
        .b           (rs2_val),
        .take_branch (w_take_branch)
    );

    ctrl_t           r_ctrl;
    logic            r_valid;
    logic [XLEN-1:0] r_alu_result;
    logic            r_take_branch;

    // Output stage: capture decode/execute results, or a bubble when not valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_ctrl        <= '0;
            r_alu_result  <= '0;
            r_take_branch <= 1'b0;
        end else if (in_valid) begin
            r_valid       <= 1'b1;
            r_ctrl        <= w_dec;
            r_alu_result  <= w_alu_result;
            r_take_branch <= w_take_branch;
        end else begin
            r_valid       <= 1'b0;
            r_ctrl        <= '0;
            r_alu_result  <= '0;
            r_take_branch <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign rd          = r_ctrl.rd;
    assign rs1         = r_ctrl.rs1;
    assign rs2         = r_ctrl.rs2;
    assign imm         = r_ctrl.imm;
    assign alu_op      = r_ctrl.alu_op;
    assign alu_src     = r_ctrl.alu_src;
    assign reg_write   = r_ctrl.reg_write;
    assign is_branch   = r_ctrl.is_branch;
    assign jal_jump    = r_ctrl.jal_jump;
    assign jalr_jump   = r_ctrl.jalr_jump;
    assign b_type      = r_ctrl.b_type;
    assign is_load     = r_ctrl.is_load;
    assign is_store    = r_ctrl.is_store;
    assign mem_type    = r_ctrl.mem_type;
    assign is_div      = r_ctrl.is_div;
    assign div_op      = r_ctrl.div_op;
    assign is_lui      = r_ctrl.is_lui;
    assign is_auipc    = r_ctrl.is_auipc;
    assign csr_we      = r_ctrl.csr_we;
    assign csr_func    = r_ctrl.csr_func;
    assign csr_addr    = r_ctrl.csr_addr;
    assign is_mret     = r_ctrl.is_mret;
    assign cpu_halt    = r_ctrl.cpu_halt;
    assign illegal     = r_ctrl.illegal;
    assign alu_result  = r_alu_result;
    assign take_branch = r_take_branch;

endmodule
`default_nettype wire

// File: tb/tb_rv32_decode_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32_decode_exec_unit
//  Brief    : Directed scoreboard bench for rv32_decode_exec_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_decode_exec_unit;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [4:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        is_branch;
        logic        jal_jump;
        logic        jalr_jump;
        logic [2:0]  b_type;
        logic        is_load;
        logic        is_store;
        logic [2:0]  mem_type;
        logic        is_div;
        logic [2:0]  div_op;
        logic        is_lui;
        logic        is_auipc;
        logic        csr_we;
        logic [2:0]  csr_func;
        logic [11:0] csr_addr;
        logic        is_mret;
        logic        cpu_halt;
        logic        illegal;
        logic [31:0] alu_result;
        logic        take_branch;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] instr, pc, rs1_val, rs2_val;
    logic        out_valid;
    logic [4:0]  rd, rs1, rs2, alu_op;
    logic [31:0] imm, alu_result;
    logic        alu_src, reg_write, is_branch, jal_jump, jalr_jump;
    logic [2:0]  b_type, mem_type, div_op, csr_func;
    logic        is_load, is_store, is_div, is_lui, is_auipc, csr_we;
    logic [11:0] csr_addr;
    logic        is_mret, cpu_halt, illegal, take_branch;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    rv32_decode_exec_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr), .pc(pc),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .out_valid(out_valid),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .alu_op(alu_op),
        .alu_src(alu_src), .reg_write(reg_write), .is_branch(is_branch),
        .jal_jump(jal_jump), .jalr_jump(jalr_jump), .b_type(b_type),
        .is_load(is_load), .is_store(is_store), .mem_type(mem_type),
        .is_div(is_div), .div_op(div_op), .is_lui(is_lui), .is_auipc(is_auipc),
        .csr_we(csr_we), .csr_func(csr_func), .csr_addr(csr_addr),
        .is_mret(is_mret), .cpu_halt(cpu_halt), .illegal(illegal),
        .alu_result(alu_result), .take_branch(take_branch)
    );

    function automatic exp_t observed();
        exp_t o;
        o = '{out_valid, rd, rs1, rs2, imm, alu_op, alu_src, reg_write, is_branch,
              jal_jump, jalr_jump, b_type, is_load, is_store, mem_type, is_div, div_op,
              is_lui, is_auipc, csr_we, csr_func, csr_addr, is_mret, cpu_halt, illegal,
              alu_result, take_branch};
        return o;
    endfunction

    function automatic exp_t base(input logic [4:0] f_rd, input logic [4:0] f_rs1,
                                  input logic [4:0] f_rs2, input logic [31:0] f_imm,
                                  input logic [31:0] f_res);
        exp_t e;
        e            = '0;
        e.valid      = 1'b1;
        e.rd         = f_rd;
        e.rs1        = f_rs1;
        e.rs2        = f_rs2;
        e.imm        = f_imm;
        e.alu_result = f_res;
        return e;
    endfunction

    task automatic check(input string tag, input exp_t e);
        exp_t o;
        o = observed();
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h required=%h", tag, o, e);
        end
    endtask

    // Drive one instruction, queue its expectation, then compare after the edge
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] b, input exp_t e);
        in_valid = v;
        instr    = ins;
        rs1_val  = a;
        rs2_val  = b;
        pc       = 32'h0000_1000;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check(tag_q.pop_front(), exp_q.pop_front());
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; in_valid = 1'b0; instr = '0; pc = '0; rs1_val = '0; rs2_val = '0;
        #2;
        check("reset_state", exp_t'('0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        e = base(5'd1, 5'd0, 5'd5, 32'd5, 32'd5);
        e.alu_src = 1'b1; e.reg_write = 1'b1;
        step("addi", 1'b1, 32'h0050_0093, 32'd0, 32'd0, e);

        e = base(5'd3, 5'd1, 5'd2, 32'd0, 32'hFFFF_FFFE);
        e.alu_op = 5'd1; e.reg_write = 1'b1;
        step("sub", 1'b1, 32'h4020_81B3, 32'd7, 32'd9, e);

        e = base(5'd3, 5'd1, 5'd2, 32'd0, 32'hF800_0000);
        e.alu_op = 5'd7; e.reg_write = 1'b1;
        step("sra", 1'b1, 32'h4020_D1B3, 32'h8000_0000, 32'd4, e);

        e = base(5'd4, 5'd1, 5'd31, 32'hFFFF_FFFF, 32'd1);
        e.alu_op = 5'd3; e.alu_src = 1'b1; e.reg_write = 1'b1;
        step("slti", 1'b1, 32'hFFF0_A213, 32'hFFFF_FFFE, 32'd0, e);

        e = base(5'd25, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'd0);
        e.is_branch = 1'b1; e.b_type = 3'b100; e.take_branch = 1'b1;
        step("blt", 1'b1, 32'hFE20_CCE3, 32'hFFFF_FFFF, 32'd1, e);

        e = base(5'd25, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'd0);
        e.is_branch = 1'b1; e.b_type = 3'b110;
        step("bltu", 1'b1, 32'hFE20_ECE3, 32'hFFFF_FFFF, 32'd1, e);

        e = base(5'd25, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'd6);
        e.is_branch = 1'b1; e.b_type = 3'b001;
        step("bne_equal", 1'b1, 32'hFE20_9CE3, 32'd3, 32'd3, e);

        e = base(5'd5, 5'd2, 5'd8, 32'd8, 32'h108);
        e.alu_src = 1'b1; e.reg_write = 1'b1; e.is_load = 1'b1; e.mem_type = 3'b010;
        step("lw", 1'b1, 32'h0081_2283, 32'h100, 32'd0, e);

        e = base(5'd12, 5'd2, 5'd5, 32'd12, 32'h20C);
        e.alu_src = 1'b1; e.is_store = 1'b1; e.mem_type = 3'b010;
        step("sw", 1'b1, 32'h0051_2623, 32'h200, 32'h55, e);

        e = base(5'd7, 5'd8, 5'd3, 32'h1234_5000, 32'd0);
        e.is_lui = 1'b1; e.reg_write = 1'b1;
        step("lui", 1'b1, 32'h1234_53B7, 32'd0, 32'd0, e);

        e = base(5'd1, 5'd2, 5'd5, 32'h305, 32'd0);
        e.csr_we = 1'b1; e.csr_func = 3'b001; e.csr_addr = 12'h305; e.reg_write = 1'b1;
        step("csrrw", 1'b1, 32'h3051_10F3, 32'd0, 32'd0, e);

        e = base(5'd0, 5'd0, 5'd2, 32'h302, 32'd0);
        e.is_mret = 1'b1;
        step("mret", 1'b1, 32'h3020_0073, 32'd0, 32'd0, e);

        e = base(5'd0, 5'd0, 5'd1, 32'd1, 32'd0);
        e.cpu_halt = 1'b1;
        step("ebreak", 1'b1, 32'h0010_0073, 32'd0, 32'd0, e);

        e = base(5'd3, 5'd1, 5'd2, 32'd0, 32'd13);
        e.is_div = 1'b1; e.div_op = 3'b100; e.reg_write = 1'b1;
        step("div", 1'b1, 32'h0220_C1B3, 32'd10, 32'd3, e);

        e = base(5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        e.illegal = 1'b1;
        step("illegal_opcode", 1'b1, 32'h0000_007F, 32'd0, 32'd0, e);

        e = base(5'd3, 5'd1, 5'd2, 32'd0, 32'd0);
        e.illegal = 1'b1;
        step("illegal_alt_f3", 1'b1, 32'h4020_91B3, 32'd0, 32'd0, e);

        step("bubble", 1'b0, 32'h0050_0093, 32'd1, 32'd2, exp_t'('0));

        e = base(5'd1, 5'd0, 5'd5, 32'd5, 32'd5);
        e.alu_src = 1'b1; e.reg_write = 1'b1;
        step("addi_again", 1'b1, 32'h0050_0093, 32'd0, 32'd0, e);

        // Asynchronous reset away from any clock edge, with input still valid
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", exp_t'('0));
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32_decode_exec_unit.md
Name: rv32_decode_exec_unit

Overview:
- RV32IM decode-and-execute slice: instruction decoder, integer ALU and branch comparator with one output register stage.
- Turns a fetched instruction plus register operands into the control bundle, ALU result and branch decision consumed by the EX/MEM pipeline.
- Divider, forwarding, memory and CSR file are external.

Parameters:
- XLEN, 32, datapath width (only 32 supported)

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- in_valid  in  1  instr/operands valid this cycle
- instr  in  32  instruction word
- pc  in  32  instruction address
- rs1_val  in  32  operand A (already forwarded)
- rs2_val  in  32  operand B (already forwarded)
- out_valid  out  1  registered in_valid
- rd, rs1, rs2  out  5 each  register indices
- imm  out  32  sign-extended immediate (I/S/B/U/J)
- alu_op  out  5  ALU operation code
- alu_src  out  1  1 = ALU B uses imm
- reg_write  out  1  writes rd
- is_branch, jal_jump, jalr_jump  out  1 each  control-flow class
- b_type  out  3  branch funct3
- is_load, is_store  out  1 each  memory class
- mem_type  out  3  load/store funct3
- is_div, div_op  out  1/3  M-extension op, funct3
- is_lui, is_auipc  out  1 each
- csr_we, csr_func, csr_addr  out  1/3/12  CSR access
- is_mret, cpu_halt, illegal  out  1 each
- alu_result  out  32  ALU output
- take_branch  out  1  branch condition true

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Reset drives every output to 0.
- Latency 1: decode, ALU and compare are combinational; all outputs are captured on posedge clk. When in_valid=0, the register loads all-zero (bubble).
- ALU operands: A = rs1_val; B = alu_src ? imm : rs2_val.
- alu_op codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
- Shifts use B[4:0]. SLT/SLTU produce 0/1.
- Opcode mapping:
  - OP (0110011): alu_src 0, reg_write 1.
  - OP-IMM (0010011): alu_src 1, reg_write 1.
  - LOAD (0000011): ADD, alu_src 1, reg_write 1, is_load.
  - STORE (0100011): ADD, alu_src 1, is_store.
  - BRANCH (1100011): is_branch, b_type = funct3.
  - JAL: jal_jump, reg_write 1.
  - JALR: jalr_jump, alu_src 1, reg_write 1.
  - LUI: is_lui, reg_write 1.
  - AUIPC: is_auipc, reg_write 1.
  - M-ext (OP with funct7 0000001): is_div 1, div_op = funct3, reg_write 1.
- take_branch = is_branch and the condition holds for b_type: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111. Otherwise 0.
- SYSTEM (1110011):
  - 0x00000073 (ECALL) and 0x00100073 (EBREAK) assert cpu_halt.
  - 0x30200073 asserts is_mret.
  - funct3 != 0 is a CSR op: csr_we 1, csr_func = funct3, csr_addr = instr[31:20], reg_write 1.
- illegal = 1 for any of:
  - unknown opcode
  - OP funct7 not 0000000/0100000/0000001, or 0100000 with funct3 other than 000/101
  - branch funct3 010/011
  - load funct3 011/110/111
  - store funct3 > 010
  - SLLI/SRLI/SRAI bad funct7
  - SYSTEM funct3 100
  - SYSTEM funct3 000 encodings other than ECALL, EBREAK, MRET
- When illegal=1: all write/memory/branch/jump enables are 0.
- reg_write is set even for rd=0; consumers gate on rd!=0.
- alu_result is also computed for non-ALU classes (e.g. LOAD address); consumers ignore it where irrelevant.

Decomposition:
- Shared package rv32_pkg: opcode constants, ALU_* codes, branch funct3 codes, SYSTEM encodings.
- Sub-modules rv32_alu and rv32_branch_cmp, both combinational, instantiated inside.
- Decoder and output register live in the top.

Test Plan:
- ADDI x1,x0,5 (0x00500093), rs1_val=0 → next cycle: rd=1, imm=5, alu_src=1, reg_write=1, alu_result=5.
- SUB x3,x1,x2 (0x402081B3), rs1_val=7, rs2_val=9 → alu_op=1, alu_result=0xFFFFFFFE. SRA (funct3 101, funct7 0100000) of 0x80000000 by 4 → 0xF8000000.
- BLT (funct3 100), rs1_val=0xFFFFFFFF, rs2_val=1 → take_branch=1. BLTU same operands → 0. Branch imm -8 sign-extends to 0xFFFFFFF8.
- LW x5,8(x2) (0x00812283), rs1_val=0x100 → is_load=1, mem_type=010, alu_result=0x108. SW → is_store=1, reg_write=0.
- CSRRW x1,0x305,x2 (0x305110F3) → csr_we=1, csr_func=001, csr_addr=0x305. 0x30200073 → is_mret=1. 0x00100073 → cpu_halt=1. DIV (0x0220C1B3) → is_div=1, div_op=100.
- Opcode 0x7F, and reset asserted mid-stream with in_valid=1 → illegal=1 with all enables 0; reset clears every output immediately, no clock edge needed.
